uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter.sv | 146 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - four-requester round-robin arbiter feeding a byte-wide UART transmitter
module uart_tx_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 2000000,
  parameter int unsigned GAP_CYCLES     = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  req_valid,
  input  logic [31:0] req_data,
  output logic [3:0]  req_ready,
  output logic        startSignal,
  output logic [7:0]  tx_data,
  input  logic        tx_done,
  input  logic        err_clr,
  output logic        busy,
  output logic [1:0]  grant_id,
  output logic        timeout_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_GAP  = 2'd2
  } state_e;

  // Terminal counts; the shared counter times both the frame wait and the gap.
  localparam logic [20:0] TO_LAST  = 21'(TIMEOUT_CYCLES - 1);
  localparam logic [20:0] GAP_LAST = 21'(GAP_CYCLES - 1);
  localparam bit          HAS_GAP  = (GAP_CYCLES > 0);

  state_e      state_q, state_d;
  logic [20:0] cnt_q, cnt_d;
  logic [1:0]  last_grant_q, last_grant_d;
  logic [1:0]  grant_id_q, grant_id_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic [3:0]  req_ready_q, req_ready_d;
  logic        start_q, start_d;
  logic        busy_q, busy_d;
  logic        err_q, err_d;

  logic        win_found;
  logic [1:0]  win_idx;
  logic [1:0]  cand;

  // Round-robin winner: search starts just after the last granted requester and wraps.
  always_comb begin
    win_found = 1'b0;
    win_idx   = last_grant_q;
    cand      = last_grant_q;
    for (int k = 1; k <= 4; k++) begin
      cand = last_grant_q + 2'(k);
      if (!win_found && req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Next-state and registered-output logic; pulses default low every cycle.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    grant_id_d   = grant_id_q;
    tx_data_d    = tx_data_q;
    req_ready_d  = 4'b0000;
    start_d      = 1'b0;
    err_d        = err_clr ? 1'b0 : err_q;

    unique case (state_q)
      S_IDLE: begin
        if (win_found) begin
          state_d      = S_WAIT;
          cnt_d        = '0;
          last_grant_d = win_idx;
          grant_id_d   = win_idx;
          tx_data_d    = req_data[win_idx*8 +: 8];
          req_ready_d  = 4'b0001 << win_idx;
          start_d      = 1'b1;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + 21'd1;
        // A done pulse coincident with our own start pulse belongs to an older frame.
        if (tx_done && !start_q) begin
          cnt_d = '0;
          if (HAS_GAP) begin
            state_d = S_GAP;
          end else begin
            state_d = S_IDLE;
          end
        end else if (cnt_q == TO_LAST) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 21'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers; reset aborts any frame in progress immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      last_grant_q <= 2'd3;
      grant_id_q   <= 2'd0;
      tx_data_q    <= 8'h00;
      req_ready_q  <= 4'b0000;
      start_q      <= 1'b0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      grant_id_q   <= grant_id_d;
      tx_data_q    <= tx_data_d;
      req_ready_q  <= req_ready_d;
      start_q      <= start_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
    end
  end

  assign req_ready   = req_ready_q;
  assign startSignal = start_q;
  assign tx_data     = tx_data_q;
  assign busy        = busy_q;
  assign grant_id    = grant_id_q;
  assign timeout_err = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - scoreboard bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

  typedef struct {
    int id;
    int data;
    int cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic        tx_done;
  logic        err_clr;
  int          sel;
  int          cyc = 0;
  int          n_chk = 0;
  int          n_fail = 0;
  exp_t        qa[$];
  exp_t        qb[$];
  exp_t        qc[$];

  // Instance A: long timeout with a 4-cycle gap; B: 50-cycle timeout, 2-cycle gap; C: no gap.
  logic [3:0] rv_a, rdy_a, rv_b, rdy_b, rv_c, rdy_c;
  logic       td_a, td_b, td_c, st_a, st_b, st_c;
  logic       busy_a, busy_b, busy_c, err_a, err_b, err_c;
  logic [7:0] txd_a, txd_b, txd_c;
  logic [1:0] gid_a, gid_b, gid_c;

  assign rv_a = (sel == 0) ? req_valid : 4'b0000;
  assign rv_b = (sel == 1) ? req_valid : 4'b0000;
  assign rv_c = (sel == 2) ? req_valid : 4'b0000;
  assign td_a = (sel == 0) && tx_done;
  assign td_b = (sel == 1) && tx_done;
  assign td_c = (sel == 2) && tx_done;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_arbiter #(.TIMEOUT_CYCLES(200), .GAP_CYCLES(4)) dut_a (
    .clk(clk), .reset(reset), .req_valid(rv_a), .req_data(req_data), .req_ready(rdy_a),
    .startSignal(st_a), .tx_data(txd_a), .tx_done(td_a), .err_clr(err_clr),
    .busy(busy_a), .grant_id(gid_a), .timeout_err(err_a));

  uart_tx_arbiter #(.TIMEOUT_CYCLES(50), .GAP_CYCLES(2)) dut_b (
    .clk(clk), .reset(reset), .req_valid(rv_b), .req_data(req_data), .req_ready(rdy_b),
    .startSignal(st_b), .tx_data(txd_b), .tx_done(td_b), .err_clr(err_clr),
    .busy(busy_b), .grant_id(gid_b), .timeout_err(err_b));

  uart_tx_arbiter #(.TIMEOUT_CYCLES(50), .GAP_CYCLES(0)) dut_c (
    .clk(clk), .reset(reset), .req_valid(rv_c), .req_data(req_data), .req_ready(rdy_c),
    .startSignal(st_c), .tx_data(txd_c), .tx_done(td_c), .err_clr(err_clr),
    .busy(busy_c), .grant_id(gid_c), .timeout_err(err_c));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic mon(input string nm, input logic [3:0] rdy, input logic [1:0] gid,
                     input logic [7:0] txd, input logic bsy, input exp_t e);
    if (e.id < 0) begin
      chk({nm, "_unexpected_start"}, 32'd1, 32'd0);
    end else begin
      chk({nm, "_grant_id"}, 32'(gid), 32'(e.id));
      chk({nm, "_tx_data"}, 32'(txd), 32'(e.data));
      chk({nm, "_req_ready"}, 32'(rdy), 32'(1 << e.id));
      chk({nm, "_busy_at_start"}, 32'(bsy), 32'd1);
      chk({nm, "_start_cycle"}, 32'(cyc), 32'(e.cyc));
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) step();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic push(input int q, input int id, input int data, input int c);
    exp_t e;
    e = '{id, data, c};
    if (q == 0) qa.push_back(e);
    else if (q == 1) qb.push_back(e);
    else qc.push_back(e);
  endtask

  task automatic pulse_done();
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    sel       = 0;
    reset     = 1'b1;
    req_valid = 4'b0000;
    req_data  = 32'h0;
    tx_done   = 1'b0;
    err_clr   = 1'b0;

    fork
      begin : monitor
        exp_t e;
        exp_t bad;
        bad = '{-1, 0, 0};
        forever begin
          @(negedge clk);
          if (st_a) begin
            if (qa.size() > 0) e = qa.pop_front(); else e = bad;
            mon("A", rdy_a, gid_a, txd_a, busy_a, e);
          end else if (rdy_a != 4'b0000) chk("A_ready_without_start", 32'(rdy_a), 32'd0);
          if (st_b) begin
            if (qb.size() > 0) e = qb.pop_front(); else e = bad;
            mon("B", rdy_b, gid_b, txd_b, busy_b, e);
          end else if (rdy_b != 4'b0000) chk("B_ready_without_start", 32'(rdy_b), 32'd0);
          if (st_c) begin
            if (qc.size() > 0) e = qc.pop_front(); else e = bad;
            mon("C", rdy_c, gid_c, txd_c, busy_c, e);
          end else if (rdy_c != 4'b0000) chk("C_ready_without_start", 32'(rdy_c), 32'd0);
        end
      end
    join_none

    // Reset state
    step();
    chk("rst_start", 32'(st_a), 32'd0);
    chk("rst_ready", 32'(rdy_a), 32'd0);
    chk("rst_tx_data", 32'(txd_a), 32'h00);
    chk("rst_grant_id", 32'(gid_a), 32'd0);
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_timeout_err", 32'(err_a), 32'd0);
    step();
    reset = 1'b0;
    step();

    // Single request; a done pulse in the start cycle must be ignored
    req_valid = 4'b0001;
    req_data  = 32'h0000_00A5;
    s = cyc + 1;
    push(0, 0, 8'hA5, s);
    wait_cyc(s);
    req_valid = 4'b0000;
    tx_done   = 1'b1;
    step();
    tx_done = 1'b0;
    chk("single_done_in_start_ignored", 32'(busy_a), 32'd1);
    step();
    chk("single_still_waiting", 32'(busy_a), 32'd1);
    wait_cyc(s + 9);
    pulse_done();
    chk("single_gap_busy", 32'(busy_a), 32'd1);
    wait_cyc(s + 13);
    chk("single_gap_last_cycle_busy", 32'(busy_a), 32'd1);
    step();
    chk("single_idle_after_gap", 32'(busy_a), 32'd0);
    chk("single_tx_data_hold", 32'(txd_a), 32'hA5);

    // Fairness: all four valid, done 100 edges after each start, spacing 100+4+1
    do_reset();
    step();
    req_data  = 32'h4433_2211;
    req_valid = 4'b1111;
    s = cyc + 1;
    for (int i = 0; i < 5; i++) begin
      push(0, i % 4, 8'h11 * ((i % 4) + 1), s);
      wait_cyc(s);
      if (i == 4) req_valid = 4'b0000;
      wait_cyc(s + 99);
      pulse_done();
      s = s + 105;
    end
    wait_cyc(s);
    chk("fair_idle_at_end", 32'(busy_a), 32'd0);
    chk("fair_grant_id_hold", 32'(gid_a), 32'd0);
    chk("fair_tx_data_hold", 32'(txd_a), 32'h11);

    // Timeout at 50 cycles; err_clr coinciding with the timeout loses
    sel = 1;
    do_reset();
    step();
    req_valid = 4'b0001;
    req_data  = 32'h0000_00B1;
    s = cyc + 1;
    push(1, 0, 8'hB1, s);
    wait_cyc(s);
    req_valid = 4'b0000;
    wait_cyc(s + 49);
    chk("to_not_yet_err", 32'(err_b), 32'd0);
    chk("to_not_yet_busy", 32'(busy_b), 32'd1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("to_err_set", 32'(err_b), 32'd1);
    chk("to_busy_low", 32'(busy_b), 32'd0);
    step();
    chk("to_err_sticky", 32'(err_b), 32'd1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("to_err_cleared", 32'(err_b), 32'd0);

    // Coincidence: done on the limit cycle wins
    step();
    req_valid = 4'b0001;
    req_data  = 32'h0000_00C2;
    s = cyc + 1;
    push(1, 0, 8'hC2, s);
    wait_cyc(s);
    req_valid = 4'b0000;
    wait_cyc(s + 49);
    pulse_done();
    chk("coin_err_stays_0", 32'(err_b), 32'd0);
    chk("coin_in_gap", 32'(busy_b), 32'd1);
    wait_cyc(s + 52);
    chk("coin_idle_after_gap", 32'(busy_b), 32'd0);

    // GAP_CYCLES=0: idle right after done, pending request granted next edge
    sel = 2;
    do_reset();
    step();
    req_valid = 4'b0001;
    req_data  = 32'h0000_003C;
    s = cyc + 1;
    push(2, 0, 8'h3C, s);
    push(2, 1, 8'h5A, s + 11);
    wait_cyc(s);
    req_valid = 4'b0000;
    wait_cyc(s + 1);
    req_valid = 4'b0010;
    req_data  = 32'h0000_5A00;
    wait_cyc(s + 9);
    pulse_done();
    chk("nogap_idle_next", 32'(busy_c), 32'd0);
    step();
    req_valid = 4'b0000;
    chk("nogap_regrant_busy", 32'(busy_c), 32'd1);
    wait_cyc(s + 15);
    pulse_done();
    chk("nogap_done_idle", 32'(busy_c), 32'd0);

    // Asynchronous reset mid-WAIT, then requester 0 wins over 2
    sel = 0;
    do_reset();
    step();
    req_valid = 4'b0001;
    req_data  = 32'h0000_005E;
    s = cyc + 1;
    push(0, 0, 8'h5E, s);
    wait_cyc(s);
    req_valid = 4'b0000;
    wait_cyc(s + 3);
    reset = 1'b1;
    #2;
    chk("arst_busy", 32'(busy_a), 32'd0);
    chk("arst_tx_data", 32'(txd_a), 32'h00);
    chk("arst_grant_id", 32'(gid_a), 32'd0);
    chk("arst_start", 32'(st_a), 32'd0);
    step();
    reset = 1'b0;
    step();
    req_valid = 4'b0101;
    req_data  = 32'h0099_0077;
    s = cyc + 1;
    push(0, 0, 8'h77, s);
    wait_cyc(s);
    req_valid = 4'b0000;
    wait_cyc(s + 5);
    pulse_done();
    wait_cyc(s + 12);
    chk("arst_final_idle", 32'(busy_a), 32'd0);

    chk("qA_drained", 32'(qa.size()), 32'd0);
    chk("qB_drained", 32'(qb.size()), 32'd0);
    chk("qC_drained", 32'(qc.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
